// File: rtl/cnn_layer_accel_trans_eg_pkg.sv
// ============================================================================
// Module : cnn_layer_accel_trans_eg_pkg
// Desc   : Meta field layout, FSM state and meta struct for the egress serializer.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package cnn_layer_accel_trans_eg_pkg;

  localparam int META_W     = 64;
  localparam int NBEAT_LSB  = 0;
  localparam int NBEAT_W    = 3;
  localparam int HDR_EN_BIT = 8;
  localparam int EOP_BIT    = 9;
  localparam int TAG_LSB    = 16;
  localparam int TAG_W      = 48;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_WAIT_VLD = 2'd1,
    ST_HDR      = 2'd2,
    ST_DATA     = 2'd3
  } state_e;

  typedef struct packed {
    logic [TAG_W-1:0]   tag;
    logic               eop;
    logic               hdr_en;
    logic [NBEAT_W-1:0] nbeat_m1;
  } meta_t;

endpackage

`default_nettype wire

// File: rtl/cnn_layer_accel_trans_eg_beat_mux.sv
// ============================================================================
// Module : cnn_layer_accel_trans_eg_beat_mux
// Desc   : Registered egress beat: payload slice by beat index or header tag.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module cnn_layer_accel_trans_eg_beat_mux
  import cnn_layer_accel_trans_eg_pkg::*;
#(
  parameter int C_PYLD_WTH = 1024,
  parameter int C_OUT_WTH  = 128
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  ld_i,
  input  logic                  hdr_i,
  input  logic                  last_i,
  input  logic [NBEAT_W-1:0]    idx_i,
  input  logic [TAG_W-1:0]      tag_i,
  input  logic [C_PYLD_WTH-1:0] pyld_i,
  output logic [C_OUT_WTH-1:0]  tdata_o,
  output logic                  tuser_o,
  output logic                  tlast_o
);

  localparam int C_BEATS = C_PYLD_WTH / C_OUT_WTH;

  logic [C_OUT_WTH-1:0] w_slice [C_BEATS];
  logic [C_OUT_WTH-1:0] w_tag_ext;
  logic [C_OUT_WTH-1:0] tdata_q;
  logic                 tuser_q;
  logic                 tlast_q;

  // Beat 0 is the least significant slice of the payload.
  for (genvar g = 0; g < C_BEATS; g++) begin : g_slice
    assign w_slice[g] = pyld_i[g*C_OUT_WTH +: C_OUT_WTH];
  end

  assign w_tag_ext = {{(C_OUT_WTH-TAG_W){1'b0}}, tag_i};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tdata_q <= '0;
      tuser_q <= 1'b0;
      tlast_q <= 1'b0;
    end else if (ld_i) begin
      tdata_q <= hdr_i ? w_tag_ext : w_slice[idx_i];
      tuser_q <= hdr_i;
      tlast_q <= last_i;
    end
  end

  assign tdata_o = tdata_q;
  assign tuser_o = tuser_q;
  assign tlast_o = tlast_q;

endmodule

`default_nettype wire

// File: rtl/cnn_layer_accel_trans_eg_ser.sv
// ============================================================================
// Module : cnn_layer_accel_trans_eg_ser
// Desc   : Drains the egress FIFO and serializes each entry onto a stream port.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module cnn_layer_accel_trans_eg_ser
  import cnn_layer_accel_trans_eg_pkg::*;
#(
  parameter int C_META_WTH = 64,
  parameter int C_PYLD_WTH = 1024,
  parameter int C_OUT_WTH  = 128
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic [C_META_WTH+C_PYLD_WTH-1:0] fifo_dout,
  input  logic                             fifo_empty,
  input  logic                             fifo_valid,
  input  logic                             fifo_rd_rst_busy,
  output logic                             fifo_rd_en,
  output logic [C_OUT_WTH-1:0]             m_tdata,
  output logic                             m_tvalid,
  input  logic                             m_tready,
  output logic                             m_tlast,
  output logic                             m_tuser,
  output logic                             busy,
  output logic [31:0]                      pkt_cnt,
  output logic                             err_unexp_vld
);

  state_e                state_q, state_d;
  logic [NBEAT_W-1:0]    idx_q, idx_d;
  logic                  tvalid_q, tvalid_d;
  logic [31:0]           pkt_cnt_q, pkt_cnt_d;
  logic                  err_q;
  logic                  run_q;
  logic [C_PYLD_WTH-1:0] pyld_q;
  meta_t                 meta_q;

  meta_t                 w_meta_new;
  logic                  w_can_rd, w_hs, w_rd_en;
  logic                  w_ld, w_ld_hdr, w_ld_last, w_src_new;
  logic [NBEAT_W-1:0]    w_ld_idx;
  logic [C_PYLD_WTH-1:0] w_pyld;
  logic [TAG_W-1:0]      w_tag;
  logic                  w_unused;

  assign w_meta_new = {fifo_dout[C_PYLD_WTH+TAG_LSB +: TAG_W],
                       fifo_dout[C_PYLD_WTH+EOP_BIT],
                       fifo_dout[C_PYLD_WTH+HDR_EN_BIT],
                       fifo_dout[C_PYLD_WTH+NBEAT_LSB +: NBEAT_W]};

  assign w_unused = ^{fifo_dout[C_PYLD_WTH+NBEAT_W +: HDR_EN_BIT-NBEAT_W],
                      fifo_dout[C_PYLD_WTH+EOP_BIT+1 +: TAG_LSB-EOP_BIT-1],
                      meta_q.hdr_en};

  // run_q keeps the read strobe low while rst_n is asserted.
  assign w_can_rd  = run_q && !fifo_empty && !fifo_rd_rst_busy;
  assign w_hs      = tvalid_q && m_tready;
  assign w_pyld    = w_src_new ? fifo_dout[C_PYLD_WTH-1:0] : pyld_q;
  assign w_tag     = w_src_new ? w_meta_new.tag : meta_q.tag;

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    tvalid_d  = tvalid_q;
    pkt_cnt_d = pkt_cnt_q;
    w_rd_en   = 1'b0;
    w_ld      = 1'b0;
    w_ld_hdr  = 1'b0;
    w_ld_idx  = '0;
    w_ld_last = 1'b0;
    w_src_new = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (w_can_rd) begin
          w_rd_en = 1'b1;
          state_d = ST_WAIT_VLD;
        end
      end
      ST_WAIT_VLD: begin
        // First beat loads straight from the FIFO output to save a cycle.
        if (fifo_valid) begin
          w_ld      = 1'b1;
          w_src_new = 1'b1;
          idx_d     = '0;
          tvalid_d  = 1'b1;
          if (w_meta_new.hdr_en) begin
            state_d  = ST_HDR;
            w_ld_hdr = 1'b1;
          end else begin
            state_d   = ST_DATA;
            w_ld_last = w_meta_new.eop && (w_meta_new.nbeat_m1 == '0);
          end
        end
      end
      ST_HDR: begin
        if (w_hs) begin
          state_d   = ST_DATA;
          w_ld      = 1'b1;
          w_ld_last = meta_q.eop && (meta_q.nbeat_m1 == '0);
        end
      end
      ST_DATA: begin
        if (w_hs) begin
          if (idx_q == meta_q.nbeat_m1) begin
            pkt_cnt_d = pkt_cnt_q + 32'd1;
            tvalid_d  = 1'b0;
            if (w_can_rd) begin
              w_rd_en = 1'b1;
              state_d = ST_WAIT_VLD;
            end else begin
              state_d = ST_IDLE;
            end
          end else begin
            idx_d     = idx_q + NBEAT_W'(1);
            w_ld      = 1'b1;
            w_ld_idx  = idx_d;
            w_ld_last = meta_q.eop && (idx_d == meta_q.nbeat_m1);
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      idx_q     <= '0;
      tvalid_q  <= 1'b0;
      pkt_cnt_q <= '0;
      err_q     <= 1'b0;
      run_q     <= 1'b0;
      pyld_q    <= '0;
      meta_q    <= '0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      tvalid_q  <= tvalid_d;
      pkt_cnt_q <= pkt_cnt_d;
      run_q     <= 1'b1;
      err_q     <= err_q | (fifo_valid && (state_q != ST_WAIT_VLD));
      if ((state_q == ST_WAIT_VLD) && fifo_valid) begin
        pyld_q <= fifo_dout[C_PYLD_WTH-1:0];
        meta_q <= w_meta_new;
      end
    end
  end

  cnn_layer_accel_trans_eg_beat_mux #(
    .C_PYLD_WTH (C_PYLD_WTH),
    .C_OUT_WTH  (C_OUT_WTH)
  ) u_beat_mux (
    .clk     (clk),
    .rst_n   (rst_n),
    .ld_i    (w_ld),
    .hdr_i   (w_ld_hdr),
    .last_i  (w_ld_last),
    .idx_i   (w_ld_idx),
    .tag_i   (w_tag),
    .pyld_i  (w_pyld),
    .tdata_o (m_tdata),
    .tuser_o (m_tuser),
    .tlast_o (m_tlast)
  );

  assign fifo_rd_en    = w_rd_en;
  assign m_tvalid      = tvalid_q;
  assign busy          = (state_q != ST_IDLE);
  assign pkt_cnt       = pkt_cnt_q;
  assign err_unexp_vld = err_q;

endmodule

`default_nettype wire
